// File: rtl/dmem_sized.sv
// dmem_sized: word-organised data memory with RISC-V sub-word loads/stores and a valid/ready handshake.
// Optional DMEM_ZERO_INIT_EN: after reset a CLEAR state zeroes one word per cycle before accepting requests.
module dmem_sized #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic        rsp_valid,
  output logic [31:0] rd,
  output logic        err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, CLEAR} state_t;

  state_t        state, state_next;
  logic [1:0]    cnt, cnt_next;
  logic          accept, done;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          misaligned, illegal, out_of_range, fault;
  logic [3:0]    be;
  logic [31:0]   wdata, word, load_val;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   res_q;
  logic          err_q;
`ifdef DMEM_ZERO_INIT_EN
  logic [AW-1:0] clr_idx;
`endif

  assign idx      = a[AW+1:2];
  assign lane     = a[1:0];
  assign word     = mem[idx];
  assign byte_sel = word[8*lane +: 8];
  assign half_sel = a[1] ? word[31:16] : word[15:0];

  // Anything at or beyond DEPTH words faults rather than aliasing onto a lower word.
  assign out_of_range = ({2'b00, a[31:2]} >= 32'(DEPTH));
  assign fault        = misaligned || illegal || out_of_range;

  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    be         = 4'b0000;
    wdata      = wd;
    load_val   = 32'd0;
    case (funct3[1:0])
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    if (we)
      illegal = funct3[2] || (funct3[1:0] == 2'b11);
    else
      illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{wd[7:0]}};
      end
      2'b01: begin
        be    = a[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd[15:0]}};
      end
      default: be = 4'b1111;
    endcase
    case (funct3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_val = word;
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = 32'd0;
    endcase
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_ready  = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid && !reset) begin
          state_next = BUSY;
          cnt_next   = 2'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt == 2'd0) begin
          done       = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 2'd1;
        end
      end
`ifdef DMEM_ZERO_INIT_EN
      CLEAR: if (clr_idx == AW'(DEPTH - 1)) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef DMEM_ZERO_INIT_EN
      state <= CLEAR;
`else
      state <= IDLE;
`endif
      cnt <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Result is formed at accept time so later input changes cannot disturb an in-flight load.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rd        <= 32'd0;
      err       <= 1'b0;
      res_q     <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      rsp_valid <= done;
      rd        <= done ? res_q : 32'd0;
      err       <= done ? err_q : 1'b0;
      if (accept) begin
        res_q <= (we || fault) ? 32'd0 : load_val;
        err_q <= fault;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && we && !fault) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
`ifdef DMEM_ZERO_INIT_EN
    if (state == CLEAR && !reset) mem[clr_idx] <= 32'd0;
`endif
  end

`ifdef DMEM_ZERO_INIT_EN
  always_ff @(posedge clk) begin
    if (reset)
      clr_idx <= '0;
    else if (state == CLEAR)
      clr_idx <= clr_idx + 1'b1;
  end
`endif

endmodule

// File: tb/tb_dmem_sized.sv
// tb_dmem_sized: directed vector bench for dmem_sized, using a LATENCY=2 and a LATENCY=3 instance (DEPTH=64).
// Shared request inputs; each instance has its own req_valid.
module tb_dmem_sized;
`ifdef DMEM_ZERO_INIT_EN
  localparam int CLEAR_CYCLES = 64;
  localparam logic [31:0] POST_RESET_10 = 32'h0000_0000;
`else
  localparam int CLEAR_CYCLES = 0;
  localparam logic [31:0] POST_RESET_10 = 32'hA522_3344;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid2, req_valid3;
  logic        ready2, ready3;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] a, wd;
  logic        rsp2, rsp3, err2, err3;
  logic [31:0] rd2, rd3;

  bit          sel3;
  logic        cur_ready, cur_rsp, cur_err;
  logic [31:0] cur_rd;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          inst3;
    bit          w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    bit          exp_err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  dmem_sized #(.DEPTH(64), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(ready2),
    .we(we), .funct3(funct3), .a(a), .wd(wd),
    .rsp_valid(rsp2), .rd(rd2), .err(err2)
  );

  dmem_sized #(.DEPTH(64), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(ready3),
    .we(we), .funct3(funct3), .a(a), .wd(wd),
    .rsp_valid(rsp3), .rd(rd3), .err(err3)
  );

  assign cur_ready = sel3 ? ready3 : ready2;
  assign cur_rsp   = sel3 ? rsp3   : rsp2;
  assign cur_rd    = sel3 ? rd3    : rd2;
  assign cur_err   = sel3 ? err3   : err2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic addVec(input bit i3, input bit w, input logic [2:0] f3, input logic [31:0] ad,
                        input logic [31:0] dt, input logic [31:0] er, input bit ee, input string nm);
    vec_t v;
    v.inst3 = i3; v.w = w; v.f3 = f3; v.addr = ad; v.data = dt;
    v.exp_rd = er; v.exp_err = ee; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic waitReady(output int n);
    n = 0;
    while (!(ready2 && ready3) && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One full transaction on the selected instance; inputs are scrambled right after accept.
  task automatic doRequest(input bit w, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] dt,
                           output logic [31:0] got_rd, output logic got_err, output int lat,
                           output logic rdy_at_rsp);
    int n;
    @(negedge clk);
    we = w; funct3 = f3; a = ad; wd = dt;
    if (sel3) req_valid3 = 1'b1; else req_valid2 = 1'b1;
    n = 0;
    while (!cur_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_timeout", {31'd0, cur_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid2 = 1'b0;
    req_valid3 = 1'b0;
    we = 1'b1; funct3 = 3'($urandom_range(0, 7)); a = $urandom; wd = $urandom;
    lat = 0; got_rd = 32'd0; got_err = 1'b0; rdy_at_rsp = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (cur_rsp) begin
        lat = i; got_rd = cur_rd; got_err = cur_err; rdy_at_rsp = cur_ready;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] r;
    logic        e, rr;
    int          lat;
    sel3 = v.inst3;
    doRequest(v.w, v.f3, v.addr, v.data, r, e, lat, rr);
    checkOutput({v.name, "_latency"}, 32'(lat), v.inst3 ? 32'd3 : 32'd2);
    checkOutput({v.name, "_rd"}, r, v.exp_rd);
    checkOutput({v.name, "_err"}, {31'd0, e}, {31'd0, v.exp_err});
    checkOutput({v.name, "_ready_at_rsp"}, {31'd0, rr}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput({v.name, "_pulse_end"}, {31'd0, cur_rsp}, 32'd0);
    checkOutput({v.name, "_rd_idle"}, cur_rd, 32'd0);
  endtask

  task automatic buildVectors();
    addVec(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, "sw_10");
    addVec(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, "lw_10");
    addVec(0, 1, 3'b010, 32'h10, 32'h11223344, 32'h0, 0, "sw_10_b");
    addVec(0, 1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 0, "sb_13");
    addVec(0, 0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFA5, 0, "lb_13");
    addVec(0, 0, 3'b100, 32'h13, 32'h0, 32'h000000A5, 0, "lbu_13");
    addVec(0, 0, 3'b010, 32'h10, 32'h0, 32'hA5223344, 0, "lw_10_b");
    addVec(0, 1, 3'b010, 32'h20, 32'h0, 32'h0, 0, "sw_20");
    addVec(0, 1, 3'b001, 32'h22, 32'h00008001, 32'h0, 0, "sh_22");
    addVec(0, 0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 0, "lh_22");
    addVec(0, 0, 3'b101, 32'h22, 32'h0, 32'h00008001, 0, "lhu_22");
    addVec(0, 1, 3'b001, 32'h20, 32'h1234BEEF, 32'h0, 0, "sh_20");
    addVec(0, 0, 3'b010, 32'h20, 32'h0, 32'h8001BEEF, 0, "lw_20");
    addVec(0, 0, 3'b000, 32'h21, 32'h0, 32'hFFFFFFBE, 0, "lb_21");
    addVec(0, 0, 3'b100, 32'h22, 32'h0, 32'h00000001, 0, "lbu_22");
    addVec(0, 0, 3'b000, 32'h23, 32'h0, 32'hFFFFFF80, 0, "lb_23");
    addVec(0, 1, 3'b000, 32'h20, 32'hFFFFFF7F, 32'h0, 0, "sb_20");
    addVec(0, 0, 3'b000, 32'h20, 32'h0, 32'h0000007F, 0, "lb_20");
    addVec(0, 0, 3'b001, 32'h20, 32'h0, 32'hFFFFBE7F, 0, "lh_20");
    addVec(0, 0, 3'b010, 32'h06, 32'h0, 32'h0, 1, "lw_mis_06");
    addVec(0, 1, 3'b010, 32'h04, 32'hCAFEF00D, 32'h0, 0, "sw_04");
    addVec(0, 1, 3'b001, 32'h05, 32'h0000FFFF, 32'h0, 1, "sh_mis_05");
    addVec(0, 0, 3'b010, 32'h04, 32'h0, 32'hCAFEF00D, 0, "lw_04");
    addVec(0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, "ld_f3_011");
    addVec(0, 0, 3'b110, 32'h10, 32'h0, 32'h0, 1, "ld_f3_110");
    addVec(0, 0, 3'b111, 32'h10, 32'h0, 32'h0, 1, "ld_f3_111");
    addVec(0, 1, 3'b100, 32'h10, 32'h0, 32'h0, 1, "st_f3_100");
    addVec(0, 1, 3'b011, 32'h10, 32'h0, 32'h0, 1, "st_f3_011");
    addVec(0, 0, 3'b010, 32'h10, 32'h0, 32'hA5223344, 0, "lw_10_c");
    addVec(0, 1, 3'b010, 32'h00, 32'h01234567, 32'h0, 0, "sw_00");
    addVec(0, 0, 3'b010, 32'h100, 32'h0, 32'h0, 1, "lw_oor_100");
    addVec(0, 1, 3'b010, 32'h100, 32'hFFFFFFFF, 32'h0, 1, "sw_oor_100");
    addVec(0, 1, 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, "sw_oor_high");
    addVec(0, 0, 3'b010, 32'h00, 32'h0, 32'h01234567, 0, "lw_00");
    addVec(0, 1, 3'b010, 32'hFC, 32'h89ABCDEF, 32'h0, 0, "sw_fc");
    addVec(0, 0, 3'b010, 32'hFC, 32'h0, 32'h89ABCDEF, 0, "lw_fc");
    addVec(0, 0, 3'b101, 32'hFE, 32'h0, 32'h000089AB, 0, "lhu_fe");
    addVec(0, 0, 3'b101, 32'h23, 32'h0, 32'h0, 1, "lhu_mis_23");
    addVec(1, 1, 3'b010, 32'h40, 32'h55AA55AA, 32'h0, 0, "l3_sw_40");
    addVec(1, 0, 3'b010, 32'h40, 32'h0, 32'h55AA55AA, 0, "l3_lw_40");
  endtask

  initial begin
    int n, nrsp, lat;
    logic [31:0] r;
    logic e, rr;
    reset = 1'b1; req_valid2 = 1'b0; req_valid3 = 1'b0;
    we = 1'b0; funct3 = 3'b000; a = 32'd0; wd = 32'd0; sel3 = 1'b0;
    buildVectors();

    repeat (2) @(negedge clk);
    checkOutput("reset_ready2", {31'd0, ready2}, 32'd0);
    checkOutput("reset_ready3", {31'd0, ready3}, 32'd0);
    checkOutput("reset_rsp", {31'd0, rsp2}, 32'd0);
    checkOutput("reset_rd", rd2, 32'd0);
    checkOutput("reset_err", {31'd0, err2}, 32'd0);
    reset = 1'b0;
    #1;
    waitReady(n);
    checkOutput("ready_wait_after_reset", 32'(n), 32'(CLEAR_CYCLES));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // A request held during BUSY must be ignored and must not disturb the in-flight load.
    sel3 = 1'b1;
    @(negedge clk);
    we = 1'b0; funct3 = 3'b010; a = 32'h40; req_valid3 = 1'b1;
    @(posedge clk); #1;
    we = 1'b1; funct3 = 3'b010; a = 32'h40; wd = 32'h0;
    @(posedge clk); #1;
    checkOutput("busy_ready", {31'd0, ready3}, 32'd0);
    checkOutput("busy_rsp_e1", {31'd0, rsp3}, 32'd0);
    @(posedge clk); #1;
    checkOutput("busy_rsp_e2", {31'd0, rsp3}, 32'd0);
    req_valid3 = 1'b0;
    @(posedge clk); #1;
    checkOutput("busy_rsp_e3", {31'd0, rsp3}, 32'd1);
    checkOutput("busy_rd", rd3, 32'h55AA55AA);
    checkOutput("busy_err", {31'd0, err3}, 32'd0);
    doRequest(1'b0, 3'b010, 32'h40, 32'h0, r, e, lat, rr);
    checkOutput("busy_reread", r, 32'h55AA55AA);

    // Reset one cycle after accept on the LATENCY=3 instance, with a store offered to the other during reset.
    @(negedge clk);
    we = 1'b0; funct3 = 3'b010; a = 32'h40; req_valid3 = 1'b1;
    checkOutput("rmb_ready_before", {31'd0, ready3}, 32'd1);
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    @(posedge clk); #1;
    checkOutput("rmb_busy", {31'd0, ready3}, 32'd0);
    reset = 1'b1; req_valid2 = 1'b1; we = 1'b1; funct3 = 3'b010; a = 32'h10; wd = 32'h0;
    #1;
    checkOutput("rmb_ready2_in_reset", {31'd0, ready2}, 32'd0);
    @(posedge clk); #1;
    checkOutput("rmb_rsp_at_reset", {31'd0, rsp3}, 32'd0);
    reset = 1'b0; req_valid2 = 1'b0;
    #1;
    checkOutput("rmb_ready_first_cycle", {31'd0, ready3}, (CLEAR_CYCLES == 0) ? 32'd1 : 32'd0);
    nrsp = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp2 || rsp3) nrsp++;
    end
    checkOutput("rmb_no_response", 32'(nrsp), 32'd0);
    waitReady(n);
    sel3 = 1'b0;
    doRequest(1'b0, 3'b010, 32'h10, 32'h0, r, e, lat, rr);
    checkOutput("post_reset_lw_10", r, POST_RESET_10);
    checkOutput("post_reset_err", {31'd0, e}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
